// File: rtl/uart_matmul_pkg.sv
// Shared types and size helpers for the byte-stream matrix-multiply core.
package uart_matmul_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 4;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_MAC,
    ST_SEND
  } state_t;

  // Accumulator must hold N full-width products without overflow.
  function automatic int calc_accw(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int calc_outb(input int accw);
    return (accw + 7) / 8;
  endfunction

  function automatic bit n_legal(input int n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

endpackage

// File: rtl/uart_matmul_stream_core_mac.sv
// Signed/unsigned multiply with clear-or-accumulate register.
module matmul_mac_unit #(
  parameter int DW   = 8,
  parameter int ACCW = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic            signed_mode,
  input  logic            en,
  input  logic            first,
  input  logic            clr,
  output logic [ACCW-1:0] acc_next
);

  logic [ACCW-1:0] a_ext;
  logic [ACCW-1:0] b_ext;
  logic [ACCW-1:0] prod;
  logic [ACCW-1:0] acc_q;

  // Extending both operands to ACCW makes a modulo-2^ACCW multiply exact,
  // since the true product always fits in ACCW signed bits.
  assign a_ext    = {{(ACCW-DW){signed_mode & a[DW-1]}}, a};
  assign b_ext    = {{(ACCW-DW){signed_mode & b[DW-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign acc_next = (first ? '0 : acc_q) + prod;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/uart_matmul_stream_core.sv
// Byte-stream NxN matrix multiplier: loads A then B, streams C = A x B
// element by element, one MAC per cycle.
//
// state   | meaning
// LOAD    | accepting A then B bytes, little-endian per element
// MAC     | accumulating C[i][j] over k = 0..N-1
// SEND    | serialising C[i][j] LSB first
module uart_matmul_stream_core
  import uart_matmul_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       signed_mode,
  input  logic       abort,
  output logic       busy,
  output logic       done
);

  localparam int INB   = DW / 8;
  localparam int ACCW  = calc_accw(N, DW);
  localparam int OUTB  = calc_outb(ACCW);
  localparam int NE    = N * N;
  localparam int AW    = $clog2(2 * NE);
  localparam int IW    = $clog2(N);
  localparam int PW    = (INB > 1) ? $clog2(INB) : 1;
  localparam int SW    = (OUTB > 1) ? $clog2(OUTB) : 1;
  localparam int SBITS = OUTB * 8;

  state_t            state_q;
  logic [DW-1:0]     mem [2*NE];
  logic [AW-1:0]     elem_cnt;
  logic [PW-1:0]     pos_cnt;
  logic [IW-1:0]     i_q, j_q, k_q;
  logic [SW-1:0]     send_left;
  logic [SBITS-1:0]  shift_q;
  logic              mode_q;
  logic              in_ready_q, out_valid_q, busy_q, done_q;

  logic              in_xfer, out_xfer;
  logic              last_pos, last_elem, k_last, i_last, j_last, send_last;
  logic [AW-1:0]     a_addr, b_addr;
  logic              mac_en, mac_clr;
  logic [ACCW-1:0]   acc_next;
  logic [SBITS-1:0]  ext_next;

  assign in_xfer   = in_valid && in_ready_q && (state_q == ST_LOAD);
  assign out_xfer  = out_valid_q && out_ready;
  assign last_pos  = (pos_cnt == PW'(INB - 1));
  assign last_elem = (elem_cnt == AW'(2 * NE - 1));
  assign k_last    = (k_q == IW'(N - 1));
  assign i_last    = (i_q == IW'(N - 1));
  assign j_last    = (j_q == IW'(N - 1));
  assign send_last = (send_left == '0);

  // A occupies the low half of the operand store, B the high half.
  assign a_addr = AW'(i_q) * AW'(N) + AW'(k_q);
  assign b_addr = AW'(NE) + AW'(k_q) * AW'(N) + AW'(j_q);

  assign mac_en  = (state_q == ST_MAC) && !abort;
  assign mac_clr = abort || ((state_q == ST_SEND) && out_xfer && send_last);

  matmul_mac_unit #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (mem[a_addr]),
    .b           (mem[b_addr]),
    .signed_mode (mode_q),
    .en          (mac_en),
    .first       (k_q == '0),
    .clr         (mac_clr),
    .acc_next    (acc_next)
  );

  always_comb begin
    ext_next = {SBITS{mode_q & acc_next[ACCW-1]}};
    ext_next[ACCW-1:0] = acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !abort && in_xfer) begin
      for (int p = 0; p < INB; p++) begin
        if (pos_cnt == PW'(p)) mem[elem_cnt][8*p +: 8] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      elem_cnt    <= '0;
      pos_cnt     <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      send_left   <= '0;
      shift_q     <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= ST_LOAD;
      elem_cnt    <= '0;
      pos_cnt     <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      send_left   <= '0;
      shift_q     <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            busy_q <= 1'b1;
            if (elem_cnt == '0 && pos_cnt == '0) mode_q <= signed_mode;
            if (last_pos) begin
              pos_cnt <= '0;
              if (last_elem) begin
                elem_cnt   <= '0;
                in_ready_q <= 1'b0;
                state_q    <= ST_MAC;
              end else begin
                elem_cnt <= elem_cnt + AW'(1);
              end
            end else begin
              pos_cnt <= pos_cnt + PW'(1);
            end
          end
        end
        ST_MAC: begin
          if (k_last) begin
            k_q         <= '0;
            shift_q     <= ext_next;
            send_left   <= SW'(OUTB - 1);
            out_valid_q <= 1'b1;
            state_q     <= ST_SEND;
          end else begin
            k_q <= k_q + IW'(1);
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (send_last) begin
              out_valid_q <= 1'b0;
              if (j_last) begin
                j_q <= '0;
                if (i_last) begin
                  i_q        <= '0;
                  state_q    <= ST_LOAD;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  in_ready_q <= 1'b1;
                end else begin
                  i_q     <= i_q + IW'(1);
                  state_q <= ST_MAC;
                end
              end else begin
                j_q     <= j_q + IW'(1);
                state_q <= ST_MAC;
              end
            end else begin
              shift_q   <= shift_q >> 8;
              send_left <= send_left - SW'(1);
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = shift_q[7:0];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_uart_matmul_stream_core.sv
// Self-checking bench: two core instances (N=2/DW=8 and N=3/DW=16) against an arithmetic model.
module tb_uart_matmul_stream_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, signed_mode, abort, sel;
  logic [7:0] in_data;
  logic       tb_in_valid, tb_out_ready;

  logic       in_valid0, out_ready0, in_ready0, out_valid0, busy0, done0;
  logic       in_valid1, out_ready1, in_ready1, out_valid1, busy1, done1;
  logic [7:0] out_data0, out_data1;
  logic       o_in_ready, o_valid, o_busy, o_done;
  logic [7:0] o_data;

  assign in_valid0  = tb_in_valid & ~sel;
  assign out_ready0 = tb_out_ready & ~sel;
  assign in_valid1  = tb_in_valid & sel;
  assign out_ready1 = tb_out_ready & sel;
  assign o_in_ready = sel ? in_ready1 : in_ready0;
  assign o_valid    = sel ? out_valid1 : out_valid0;
  assign o_data     = sel ? out_data1 : out_data0;
  assign o_busy     = sel ? busy1 : busy0;
  assign o_done     = sel ? done1 : done0;

  uart_matmul_stream_core #(.N(2), .DW(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .signed_mode(signed_mode), .abort(abort), .busy(busy0), .done(done0));

  uart_matmul_stream_core #(.N(3), .DW(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .signed_mode(signed_mode), .abort(abort), .busy(busy1), .done(done1));

  int tests = 0;
  int fails = 0;
  longint a_m[16];
  longint b_m[16];
  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  int g_outb;

  function automatic int clog2i(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic longint opval(input longint raw, input int dw, input bit sm);
    if (sm && raw[dw-1]) return raw - (longint'(1) << dw);
    return raw;
  endfunction

  task automatic build_expected(input int n, input int dw, input bit sm);
    longint s;
    int inb;
    inb = dw / 8;
    g_outb = (2 * dw + clog2i(n) + 7) / 8;
    in_q.delete();
    exp_q.delete();
    for (int e = 0; e < n * n; e++)
      for (int p = 0; p < inb; p++) in_q.push_back(8'(a_m[e] >> (8 * p)));
    for (int e = 0; e < n * n; e++)
      for (int p = 0; p < inb; p++) in_q.push_back(8'(b_m[e] >> (8 * p)));
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += opval(a_m[i*n+k], dw, sm) * opval(b_m[k*n+j], dw, sm);
        for (int b = 0; b < g_outb; b++) exp_q.push_back(8'(s >>> (8 * b)));
      end
  endtask

  task automatic set_2x2(input longint a0, a1, a2, a3, b0, b1, b2, b3);
    a_m[0] = a0; a_m[1] = a1; a_m[2] = a2; a_m[3] = a3;
    b_m[0] = b0; b_m[1] = b1; b_m[2] = b2; b_m[3] = b3;
  endtask

  task automatic run_job(input int n, input int dw, input bit sm, input bit bp, input string name);
    int idx, cyc, last_in_cyc, first_ov_cyc, done_cyc, done_cnt;
    bit stall_prev, r, busy_at_done, ir_at_done, extra_valid;
    logic [7:0] data_prev;
    logic [7:0] got[$];
    build_expected(n, dw, sm);
    idx = 0; cyc = 0; last_in_cyc = -1; first_ov_cyc = -1; done_cyc = -1; done_cnt = 0;
    stall_prev = 0; busy_at_done = 1; ir_at_done = 0; extra_valid = 0; data_prev = '0;
    while (done_cnt == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (o_done) begin
        done_cnt++; done_cyc = cyc; busy_at_done = o_busy; ir_at_done = o_in_ready;
      end
      if (stall_prev) begin
        tests++;
        if (o_valid !== 1'b1 || o_data !== data_prev) begin
          fails++;
          $display("FAIL %s stall_hold: got valid=%b data=%h want valid=1 data=%h", name, o_valid, o_data, data_prev);
        end
      end
      if (o_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      r = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      tb_out_ready = r;
      if (o_valid && r) got.push_back(o_data);
      stall_prev = o_valid && !r;
      data_prev = o_data;
      if (idx < in_q.size() && (!bp || $urandom_range(0, 3) != 0)) begin
        tb_in_valid = 1'b1;
        in_data = in_q[idx];
        signed_mode = (idx == 0) ? sm : 1'($urandom_range(0, 1));
        if (o_in_ready) begin
          idx++;
          if (idx == in_q.size()) last_in_cyc = cyc;
        end
      end else begin
        tb_in_valid = 1'b0;
      end
    end
    tb_in_valid = 1'b0;
    tests++;
    if (done_cnt == 0) begin
      fails++;
      $display("FAIL %s timeout: got no done after %0d cycles, want done", name, cyc);
    end
    repeat (3) begin
      @(negedge clk);
      if (o_done) done_cnt++;
      if (o_valid) extra_valid = 1;
    end
    tests++;
    if (got.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s byte_count: got %0d want %0d", name, got.size(), exp_q.size());
    end
    for (int b = 0; b < got.size() && b < exp_q.size(); b++) begin
      tests++;
      if (got[b] !== exp_q[b]) begin
        fails++;
        $display("FAIL %s byte[%0d]: got %h want %h", name, b, got[b], exp_q[b]);
      end
    end
    tests++;
    if (done_cnt != 1 || extra_valid) begin
      fails++;
      $display("FAIL %s done_pulse: got %0d pulses extra_valid=%b want 1 pulse no valid", name, done_cnt, extra_valid);
    end
    tests++;
    if (busy_at_done !== 1'b0 || ir_at_done !== 1'b1) begin
      fails++;
      $display("FAIL %s status_at_done: got busy=%b in_ready=%b want busy=0 in_ready=1", name, busy_at_done, ir_at_done);
    end
    if (!bp) begin
      tests++;
      if (first_ov_cyc - last_in_cyc != n + 1) begin
        fails++;
        $display("FAIL %s latency: got %0d want %0d", name, first_ov_cyc - last_in_cyc, n + 1);
      end
      tests++;
      if (done_cyc - last_in_cyc != n * n * (n + g_outb) + 1) begin
        fails++;
        $display("FAIL %s job_length: got %0d want %0d", name, done_cyc - last_in_cyc, n * n * (n + g_outb) + 1);
      end
    end
  endtask

  task automatic load_bytes(input int cnt, input string name);
    int idx, cyc;
    idx = 0; cyc = 0;
    while (idx < cnt && cyc < 500) begin
      @(negedge clk);
      cyc++;
      tb_in_valid = 1'b1;
      in_data = in_q[idx];
      if (o_in_ready) idx++;
    end
    tests++;
    if (idx < cnt) begin
      fails++;
      $display("FAIL %s load_timeout: got %0d bytes want %0d", name, idx, cnt);
    end
  endtask

  task automatic wait_valid(input string name);
    int cyc;
    cyc = 0;
    tb_out_ready = 1'b0;
    do begin
      @(negedge clk);
      tb_in_valid = 1'b0;
      cyc++;
    end while (!o_valid && cyc < 100);
    tests++;
    if (!o_valid) begin
      fails++;
      $display("FAIL %s wait_valid: got out_valid=0 want 1", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (o_in_ready !== 1'b0 || o_valid !== 1'b0 || o_data !== 8'h00 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got ir=%b ov=%b od=%h busy=%b done=%b want all 0", o_in_ready, o_valid, o_data, o_busy, o_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got in_ready=%b busy=%b want 1 0", o_in_ready, o_busy);
    end
  endtask

  task automatic test_directed();
    set_2x2(1, 2, 3, 4, 5, 6, 7, 8);
    run_job(2, 8, 0, 0, "unsigned_basic");
    set_2x2(8'hFF, 0, 0, 8'hFF, 2, 3, 4, 5);
    run_job(2, 8, 1, 0, "signed_neg_identity");
    set_2x2(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_job(2, 8, 0, 0, "unsigned_max");
  endtask

  task automatic test_backpressure();
    set_2x2(1, 2, 3, 4, 5, 6, 7, 8);
    run_job(2, 8, 0, 1, "backpressure");
    set_2x2(8'h80, 8'h7F, 8'hFF, 8'h80, 8'h80, 8'h01, 8'h7F, 8'hFE);
    run_job(2, 8, 1, 1, "backpressure_signed");
  endtask

  task automatic test_back_to_back();
    set_2x2(8'hFF, 0, 0, 8'hFF, 2, 3, 4, 5);
    run_job(2, 8, 1, 0, "b2b_first");
    set_2x2(1, 2, 3, 4, 5, 6, 7, 8);
    run_job(2, 8, 0, 0, "b2b_second");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int e = 0; e < 4; e++) begin
        a_m[e] = longint'($urandom_range(0, 255));
        b_m[e] = longint'($urandom_range(0, 255));
      end
      run_job(2, 8, 1'($urandom_range(0, 1)), 1'(it % 2), "random");
    end
  endtask

  task automatic test_abort_load();
    bit bad;
    set_2x2(1, 2, 3, 4, 5, 6, 7, 8);
    build_expected(2, 8, 0);
    signed_mode = 1'b0;
    tb_out_ready = 1'b1;
    load_bytes(5, "abort_load");
    @(negedge clk);
    abort = 1'b1;
    tb_in_valid = 1'b1;
    in_data = in_q[5];
    @(negedge clk);
    abort = 1'b0;
    tb_in_valid = 1'b0;
    tests++;
    if (o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_load_status: got ir=%b busy=%b ov=%b want 1 0 0", o_in_ready, o_busy, o_valid);
    end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_valid || o_done) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL abort_load_quiet: got output or done after abort, want none");
    end
    run_job(2, 8, 0, 0, "after_abort_load");
  endtask

  task automatic test_abort_send();
    set_2x2(1, 2, 3, 4, 5, 6, 7, 8);
    build_expected(2, 8, 0);
    signed_mode = 1'b0;
    load_bytes(8, "abort_send");
    wait_valid("abort_send");
    abort = 1'b1;
    tb_out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_send_status: got ov=%b ir=%b busy=%b done=%b want 0 1 0 0", o_valid, o_in_ready, o_busy, o_done);
    end
    set_2x2(8'hFF, 0, 0, 8'hFF, 2, 3, 4, 5);
    run_job(2, 8, 1, 0, "after_abort_send");
  endtask

  task automatic test_reset_send();
    set_2x2(1, 2, 3, 4, 5, 6, 7, 8);
    build_expected(2, 8, 0);
    signed_mode = 1'b0;
    load_bytes(8, "reset_send");
    wait_valid("reset_send");
    rst_n = 1'b0;
    tb_out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b0 || o_in_ready !== 1'b0 || o_busy !== 1'b0 || o_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_send_during: got ov=%b ir=%b busy=%b od=%h want 0 0 0 00", o_valid, o_in_ready, o_busy, o_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (o_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_send_after: got in_ready=%b want 1", o_in_ready);
    end
    run_job(2, 8, 0, 0, "after_reset_send");
  endtask

  task automatic test_n3_identity();
    sel = 1'b1;
    @(negedge clk);
    for (int e = 0; e < 9; e++) begin
      a_m[e] = (e % 4 == 0) ? 1 : 0;
      b_m[e] = longint'($urandom_range(0, 65535));
    end
    b_m[0] = 16'h8000;
    b_m[8] = 16'hFFFF;
    run_job(3, 16, 0, 0, "n3_identity_unsigned");
    run_job(3, 16, 1, 1, "n3_identity_signed_bp");
    sel = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    signed_mode = 1'b0;
    abort = 1'b0;
    sel = 1'b0;
    in_data = 8'h00;
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_abort_load();
    test_abort_send();
    test_reset_send();
    test_n3_identity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
